// File: rtl/apb_uart_tx.sv
// APB slave UART transmitter: TX FIFO plus 8N1 serialiser.
// Registers: TXDATA, STATUS, BAUDDIV, CTRL.
module apb_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        txd,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic [15:0]   baud;
    logic [1:0]    ctrl;
    logic          arm_q;
    logic [15:0]   div_q, div_d;
    logic [15:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          pop;

    logic       access, wr, full, empty, push, busy, tx_en, bit_end;
    logic [2:0] idx;
    logic [3:0] cnt4;
    logic [31:0] status;
    logic [15:0] div_eff;

    assign access  = PSEL & PENABLE;
    assign wr      = access & PWRITE;
    assign idx     = PADDR[4:2];
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push    = wr & (idx == 3'd0) & ~full;
    assign busy    = (state_q != IDLE);
    assign tx_en   = ctrl[0];
    assign cnt4    = 4'(count);
    assign status  = {24'b0, cnt4, 1'b0, busy, empty, full};
    assign div_eff = (baud == 16'd0) ? 16'd1 : baud;
    assign bit_end = (bit_cnt_q == div_q - 16'd1);

    assign PREADY  = 1'b1;
    assign PSLVERR = access & ((PWRITE & (idx == 3'd0) & full) | (idx > 3'd3));
    assign txd     = txd_q;
    assign irq     = ctrl[1] & empty;

    always_comb begin
        PRDATA = 32'b0;
        if (PSEL & ~PWRITE) begin
            case (idx)
                3'd1:    PRDATA = status;
                3'd2:    PRDATA = {16'b0, baud};
                3'd3:    PRDATA = {30'b0, ctrl};
                default: PRDATA = 32'b0;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wp] <= PWDATA[7:0];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            baud  <= DIV_RESET;
            ctrl  <= 2'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr && idx == 3'd2) baud <= PWDATA[15:0];
            if (wr && idx == 3'd3) ctrl <= PWDATA[1:0];
        end
    end

    // Frame start waits one extra cycle after the FIFO goes non-empty.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            arm_q     <= 1'b0;
            div_q     <= 16'd1;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            arm_q     <= (state_q == IDLE) & tx_en & ~empty;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm_q & tx_en & ~empty) begin
                    pop       = 1'b1;
                    shift_d   = mem[rp];
                    div_d     = div_eff;
                    bit_cnt_d = '0;
                    txd_d     = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (tx_en & ~empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rp];
                        div_d   = div_eff;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx with a byte scoreboard
// checked against the serial txd waveform.
module tb_apb_uart_tx;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [4:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, txd, irq;

    int total = 0;
    int bad = 0;
    logic [7:0] sb[$];

    apb_uart_tx dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .txd(txd), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d,
                             output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d,
                            output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 d = PRDATA; err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Setup-phase-only read: PRDATA is combinational, no edge consumed.
    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        #1 d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic exp_err);
        logic e;
        apb_write(5'h00, {24'b0, b}, e);
        chk($sformatf("txdata_err_%0h", b), e, exp_err);
        if (!exp_err) sb.push_back(b);
    endtask

    task automatic wait_fall(input int lim);
        logic found = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge PCLK); #1;
            if (txd === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("fall_timeout", found, 1'b1);
    endtask

    task automatic check_frame(input int div, input bit pre, input bit chk_busy);
        logic [7:0]  b;
        logic [9:0]  fb;
        logic [31:0] d;
        logic        ok;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        b = sb.pop_front();
        fb = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            ok = 1'b1;
            for (int c = 0; c < div; c++) begin
                if (k > 0 || c > 0 || !pre) begin
                    @(posedge PCLK); #1;
                end
                if (txd !== fb[k]) ok = 1'b0;
                if (chk_busy && k == 9 && c == div - 1) begin
                    peek(5'h04, d);
                    chk("busy_last_cycle", d[2], 1'b1);
                end
            end
            chk($sformatf("byte_%0h_bit%0d", b, k), ok, 1'b1);
        end
    endtask

    task automatic stay_idle(input string tag, input int n);
        logic ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
            if (txd !== 1'b1) ok = 1'b0;
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic latency_check;
        chk("lat_e0", txd, 1'b1);
        @(posedge PCLK); #1;
        chk("lat_e1", txd, 1'b1);
        @(posedge PCLK); #1;
        chk("lat_e2_low", txd, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;

        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;

        apb_read(5'h04, d, e);
        chk("rst_status", d, 32'h02);
        chk("rst_status_err", e, 1'b0);
        chk("rst_txd", txd, 1'b1);
        chk("rst_irq", irq, 1'b0);
        chk("rst_pready", PREADY, 1'b1);
        apb_read(5'h08, d, e);
        chk("rst_baud", d, 32'd434);

        apb_write(5'h08, 32'd4, e);
        apb_write(5'h0C, 32'd1, e);
        send(8'hA5, 1'b0);
        latency_check();
        check_frame(4, 1'b1, 1'b1);
        @(posedge PCLK); #1;
        peek(5'h04, d);
        chk("busy_drop", d[2], 1'b0);
        chk("idle_txd", txd, 1'b1);

        apb_write(5'h0C, 32'd0, e);
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
        send(8'hEE, 1'b1);
        peek(5'h04, d);
        chk("status_full", d, 32'h81);
        apb_write(5'h0C, 32'd1, e);
        wait_fall(10);
        check_frame(4, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) check_frame(4, 1'b0, 1'b0);
        @(posedge PCLK); #1;
        peek(5'h04, d);
        chk("drained_status", d, 32'h02);
        stay_idle("no_9th_byte", 100);
        chk("irq_off", irq, 1'b0);
        apb_write(5'h0C, 32'd3, e);
        chk("irq_on", irq, 1'b1);

        apb_write(5'h0C, 32'd0, e);
        apb_write(5'h08, 32'd2, e);
        send(8'h3C, 1'b0);
        send(8'hC3, 1'b0);
        chk("irq_nonempty", irq, 1'b0);
        apb_write(5'h0C, 32'd1, e);
        wait_fall(10);
        check_frame(2, 1'b1, 1'b0);
        check_frame(2, 1'b0, 1'b0);
        @(posedge PCLK); #1;
        chk("b2b_end_txd", txd, 1'b1);

        apb_write(5'h0C, 32'd0, e);
        send(8'h96, 1'b0);
        send(8'h69, 1'b0);
        apb_write(5'h0C, 32'd1, e);
        wait_fall(10);
        fork
            check_frame(2, 1'b1, 1'b0);
            begin
                repeat (4) @(posedge PCLK);
                apb_write(5'h08, 32'd3, e);
            end
        join
        check_frame(3, 1'b0, 1'b0);
        @(posedge PCLK); #1;
        chk("div3_end_txd", txd, 1'b1);

        apb_write(5'h0C, 32'd0, e);
        send(8'h81, 1'b0);
        send(8'h7E, 1'b0);
        apb_write(5'h0C, 32'd1, e);
        wait_fall(10);
        fork
            check_frame(3, 1'b1, 1'b0);
            begin
                repeat (5) @(posedge PCLK);
                apb_write(5'h0C, 32'd0, e);
            end
        join
        @(posedge PCLK); #1;
        peek(5'h04, d);
        chk("txen_off_status", d, 32'h10);
        stay_idle("txen_off_idle", 40);

        apb_write(5'h0C, 32'd1, e);
        wait_fall(10);
        repeat (14) begin
            @(posedge PCLK); #1;
        end
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        chk("midframe_rst_txd", txd, 1'b1);
        PRESET = 1'b0;
        void'(sb.pop_front());
        peek(5'h04, d);
        chk("midframe_rst_status", d, 32'h02);
        peek(5'h08, d);
        chk("midframe_rst_baud", d, 32'd434);
        stay_idle("post_rst_idle", 60);

        apb_read(5'h14, d, e);
        chk("unmapped_rd_data", d, 32'h0);
        chk("unmapped_rd_err", e, 1'b1);
        apb_write(5'h1C, 32'hFF, e);
        chk("unmapped_wr_err", e, 1'b1);
        apb_read(5'h00, d, e);
        chk("txdata_rd", d, 32'h0);
        chk("txdata_rd_err", e, 1'b0);
        apb_write(5'h08, 32'd0, e);
        apb_read(5'h08, d, e);
        chk("baud_zero_rb", d, 32'h0);
        apb_write(5'h0C, 32'd1, e);
        send(8'h5A, 1'b0);
        latency_check();
        check_frame(1, 1'b1, 1'b1);
        @(posedge PCLK); #1;
        peek(5'h04, d);
        chk("div1_done", d, 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL global_timeout");
    end

endmodule
